// File: rtl/m_opqueue.sv
// m_opqueue: DEPTH-entry instruction queue between the input mux and the
// decode field taps. Fetch pushes with wr, execute pops with adv, a taken
// branch or trap discards every prefetched word with flush. The head entry
// drives INSTR and the RV32 register/function fields; INSTR reads as zero
// whenever there is no valid head, so execute sees a NOP-equivalent word.
module m_opqueue #(
    parameter int DEPTH     = 2,
    parameter bit BYPASS    = 1'b0,
    parameter bit HIGHLEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic [31:0] Di,
    input  logic        adv,
    input  logic        flush,
    output logic [31:0] INSTR,
    output logic        ivalid,
    output logic        full,
    output logic [3:0]  cnt,
    output logic        ovf,
    output logic        unf,
    output logic [4:0]  TRG,
    output logic [4:0]  SRC1,
    output logic [4:0]  SRC2,
    output logic [2:0]  FUNC3,
    output logic [6:0]  FUNC7
);

    // Pointer width is at least one bit so DEPTH=1 still has a legal vector;
    // the slot array is rounded up to a power of two so every pointer value
    // indexes a real slot (slots at or above DEPTH are never written).
    localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             NSLOT   = 1 << PW;
    localparam logic [3:0]     DEPTH_C = 4'(DEPTH);
    localparam logic [PW-1:0]  LAST_C  = PW'(DEPTH - 1);

    // Circular increment: wraps DEPTH-1 -> 0, so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST_C) begin
            r = PW'(0);
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    logic [3:0]    cnt_r;
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic          ovf_r;
    logic          unf_r;

    logic [31:0]   entry_s [NSLOT];
    logic          empty_s;
    logic          full_s;
    logic          byp_s;
    logic          ivalid_s;
    logic          push_s;
    logic          pop_s;
    logic          ovf_set_s;
    logic          unf_set_s;
    logic [3:0]    cnt_nxt_s;
    logic [31:0]   instr_s;

    // Queue status and the push/pop decisions; flush suppresses everything.
    always_comb begin
        empty_s   = (cnt_r == 4'd0);
        full_s    = (cnt_r == DEPTH_C);
        byp_s     = (BYPASS == 1'b1) && empty_s && wr;
        ivalid_s  = !empty_s || byp_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (flush) begin
            push_s    = 1'b0;
            pop_s     = 1'b0;
        end else begin
            // At full a concurrent pop frees the slot being written.
            push_s    = wr && (!full_s || adv);
            // In bypass the word being written counts as a valid head, so a
            // same-cycle pop consumes it; both pointers then step together.
            pop_s     = adv && ivalid_s;
            ovf_set_s = wr && full_s && !adv;
            unf_set_s = adv && !ivalid_s;
        end
    end

    // Next occupancy: push and pop together leave the count unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + 4'd1;
            2'b01:   cnt_nxt_s = cnt_r - 4'd1;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Occupancy, pointers and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 4'd0;
            wptr_r <= PW'(0);
            rptr_r <= PW'(0);
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else if (flush) begin
            // Error flags survive a flush; only reset clears them.
            cnt_r  <= 4'd0;
            wptr_r <= PW'(0);
            rptr_r <= PW'(0);
        end else begin
            cnt_r <= cnt_nxt_s;
            if (push_s) begin
                wptr_r <= ptr_inc(wptr_r);
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            ovf_r <= ovf_r | ovf_set_s;
            unf_r <= unf_r | unf_set_s;
        end
    end

    generate
        if (HIGHLEVEL) begin : g_beh
            logic [31:0] mem_r [NSLOT];

            // Behavioural storage: one indexed write port.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NSLOT; i++) begin
                        mem_r[i] <= 32'd0;
                    end
                end else if (push_s) begin
                    mem_r[wptr_r] <= Di;
                end
            end

            assign entry_s = mem_r;
        end else begin : g_dffe
            for (genvar g = 0; g < NSLOT; g++) begin : g_slot
                if (g < DEPTH) begin : g_live
                    logic        en_s;
                    logic [31:0] q_r;

                    assign en_s = push_s && (wptr_r == PW'(g));

                    // One enable-flop word per slot, enable decoded from wptr.
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            q_r <= 32'd0;
                        end else if (en_s) begin
                            q_r <= Di;
                        end
                    end

                    assign entry_s[g] = q_r;
                end else begin : g_pad
                    assign entry_s[g] = 32'd0;
                end
            end
        end
    endgenerate

    // Head selection: stored head, else the bypassed input, else zero.
    always_comb begin
        if (!empty_s) begin
            instr_s = entry_s[rptr_r];
        end else if (byp_s) begin
            instr_s = Di;
        end else begin
            instr_s = 32'd0;
        end
    end

    assign INSTR  = instr_s;
    assign ivalid = ivalid_s;
    assign full   = full_s;
    assign cnt    = cnt_r;
    assign ovf    = ovf_r;
    assign unf    = unf_r;
    assign TRG    = instr_s[11:7];
    assign SRC1   = instr_s[19:15];
    assign SRC2   = instr_s[24:20];
    assign FUNC3  = instr_s[14:12];
    assign FUNC7  = instr_s[31:25];

endmodule
